// File: rtl/cfi_pkg.sv
// cfi_pkg: shared encodings, label layout and state types for the CFI landing-pad checker.
package cfi_pkg;

    localparam int LOWER_W = 9;
    localparam int MID_W   = 8;
    localparam int UPPER_W = 8;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_LOWER   = 7'b1000001;
    localparam logic [6:0] F7_MIDUP   = 7'b1000011;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LPSLL,
        OP_LPCLL,
        OP_SML,
        OP_CML,
        OP_SUL,
        OP_CUL
    } cfi_op_e;

    typedef enum logic [1:0] {
        CAUSE_NO_LP,
        CAUSE_LOWER,
        CAUSE_MID,
        CAUSE_UPPER
    } viol_cause_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LP,
        LANDED,
        VIOL
    } state_e;

    typedef struct packed {
        logic [UPPER_W-1:0] upper;
        logic [MID_W-1:0]   mid;
        logic [LOWER_W-1:0] lower;
    } cfi_label_t;

    // x1/x5 are the ABI link registers; transfers through them are returns.
    function automatic logic is_link(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

endpackage

// File: rtl/cfi_decoder.sv
// cfi_decoder: classifies a retiring instruction as a CFI label op and/or an indirect transfer.
module cfi_decoder
    import cfi_pkg::*;
(
    input  logic        [31:0] instr,
    input  logic               is_comp,
    output cfi_op_e            op,
    output logic [LOWER_W-1:0] label,
    output logic               indirect
);

    logic       cfi_form;
    logic       is_lower;
    logic       is_midup;
    logic [1:0] sel;
    logic       jalr;
    logic       c_jr_form;

    assign cfi_form = !is_comp && instr[6:0] == OPC_OP_IMM && instr[14:12] == 3'b100 && instr[11:7] == 5'd0;
    assign is_lower = cfi_form && instr[31:25] == F7_LOWER;
    assign is_midup = cfi_form && instr[31:25] == F7_MIDUP;
    assign sel      = instr[24:23];

    always_comb begin
        op = is_lower ? (instr[24] ? OP_LPCLL : OP_LPSLL) :
             is_midup ? (sel == 2'b00 ? OP_SML : sel == 2'b01 ? OP_CML : sel == 2'b10 ? OP_SUL : OP_CUL) :
             OP_NONE;
        label = is_lower ? instr[23:15] : {1'b0, instr[22:15]};
    end

    // C.JR/C.JALR share the CR encoding; bit 12 separates them.
    assign jalr      = !is_comp && instr[6:0] == OPC_JALR && instr[14:12] == 3'b000 &&
                       !(instr[11:7] == 5'd0 && is_link(instr[19:15]));
    assign c_jr_form = is_comp && instr[1:0] == 2'b10 && instr[15:13] == 3'b100 &&
                       instr[11:7] != 5'd0 && instr[6:2] == 5'd0;
    assign indirect  = jalr || (c_jr_form && (instr[12] || !is_link(instr[11:7])));

endmodule

// File: rtl/cfi_lp_checker.sv
// cfi_lp_checker: commit-stage forward-edge CFI landing-pad enforcement with violation handshake.
// Define CFI_LP_STATS_EN to add saturating landing/violation counters (land_cnt_o, viol_cnt_o).
module cfi_lp_checker
    import cfi_pkg::*;
#(
    parameter int VLEN = 64
`ifdef CFI_LP_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    output logic            commit_ready_o,
    input  logic [31:0]     commit_instr_i,
    input  logic            commit_is_comp_i,
    input  logic [VLEN-1:0] commit_pc_i,
    output logic            viol_valid_o,
    input  logic            viol_ready_i,
    output logic [VLEN-1:0] viol_tval_o,
    output logic [1:0]      viol_cause_o,
    output logic [24:0]     exp_label_o
`ifdef CFI_LP_STATS_EN
    , output logic [CNT_W-1:0] land_cnt_o,
    output logic [CNT_W-1:0] viol_cnt_o
`endif
);

    state_e             state;
    state_e             state_d;
    viol_cause_e        cause;
    viol_cause_e        cause_d;
    cfi_label_t         lbl;
    logic [VLEN-1:0]    tval;
    cfi_op_e            op;
    logic [LOWER_W-1:0] label;
    logic               indirect;
    logic               retire;
    logic               load;

    cfi_decoder u_dec (
        .instr    (commit_instr_i),
        .is_comp  (commit_is_comp_i),
        .op       (op),
        .label    (label),
        .indirect (indirect)
    );

    // A flush wins over the instruction retiring alongside it.
    assign retire = commit_valid_i && commit_ready_o && !flush_i;

    always_comb begin
        state_d = state;
        cause_d = CAUSE_NO_LP;
        case (state)
            IDLE: state_d = (retire && en_i && indirect) ? WAIT_LP : IDLE;
            WAIT_LP: if (retire) begin
                state_d = (op == OP_LPCLL && label == lbl.lower) ? LANDED : VIOL;
                cause_d = (op == OP_LPCLL) ? CAUSE_LOWER : CAUSE_NO_LP;
            end
            LANDED: if (retire) begin
                state_d = (op == OP_CML) ? ((label[MID_W-1:0] == lbl.mid) ? LANDED : VIOL) :
                          (op == OP_CUL) ? ((label[UPPER_W-1:0] == lbl.upper) ? IDLE : VIOL) :
                          indirect ? WAIT_LP : IDLE;
                cause_d = (op == OP_CML) ? CAUSE_MID : CAUSE_UPPER;
            end
            default: state_d = viol_ready_i ? IDLE : VIOL;
        endcase
        if (!en_i && (state == WAIT_LP || state == LANDED)) state_d = IDLE;
        if (flush_i) state_d = IDLE;
    end

    assign load = state_d == VIOL && state != VIOL;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            lbl   <= '0;
            tval  <= '0;
            cause <= CAUSE_NO_LP;
        end else begin
            state <= state_d;
            if (load) begin
                tval  <= commit_pc_i;
                cause <= cause_d;
            end
            if (retire && op == OP_LPSLL) lbl.lower <= label;
            if (retire && op == OP_SML) lbl.mid <= label[MID_W-1:0];
            if (retire && op == OP_SUL) lbl.upper <= label[UPPER_W-1:0];
        end
    end

    assign commit_ready_o = state != VIOL;
    assign viol_valid_o   = state == VIOL;
    assign viol_tval_o    = tval;
    assign viol_cause_o   = cause;
    assign exp_label_o    = lbl;

`ifdef CFI_LP_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            land_cnt_o <= '0;
            viol_cnt_o <= '0;
        end else begin
            if (state == WAIT_LP && state_d == LANDED && !(&land_cnt_o)) land_cnt_o <= land_cnt_o + 1'b1;
            if (viol_valid_o && viol_ready_i && !(&viol_cnt_o)) viol_cnt_o <= viol_cnt_o + 1'b1;
        end
    end
`endif

endmodule
